ring_tdm_link_scheduler: RTL

- Time-division scheduler that shares one ring output link between two security-domain queues: domain 0 (L) and domain 1 (H).
- Sits between the two per-domain queue dequeue interfaces and the link's downstream queue enqueue interface.
- Grants the link on a fixed, traffic-independent slot schedule, with guard cycles at every domain switch. Neither domain's traffic can modulate the other's timing.
- Drives the downstream queue's domain_signal.

---
 rtl/ring_tdm_link_scheduler.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ring_tdm_link_scheduler.sv
// Fixed-schedule TDM arbiter sharing one ring link between two security domains.
// Slot ownership follows a traffic-independent counter so neither domain can modulate the other's timing.
module ring_tdm_link_scheduler #(
    parameter int p_msg_nbits    = 8,
    parameter int p_slot_cycles  = 4,
    parameter int p_guard_cycles = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   in0_val,
    output logic                   in0_rdy,
    input  logic [p_msg_nbits-1:0] in0_msg,
    input  logic                   in1_val,
    output logic                   in1_rdy,
    input  logic [p_msg_nbits-1:0] in1_msg,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [p_msg_nbits-1:0] out_msg,
    output logic                   out_domain,
    output logic                   guard,
    output logic [15:0]            xfer_cnt0,
    output logic [15:0]            xfer_cnt1
);

    localparam int c_cnt_max   = (p_slot_cycles > p_guard_cycles) ? p_slot_cycles : p_guard_cycles;
    localparam int c_cnt_nbits = $clog2((c_cnt_max > 2) ? c_cnt_max : 2);
    localparam logic [c_cnt_nbits-1:0] c_slot_ld  = c_cnt_nbits'(p_slot_cycles - 1);
    localparam logic [c_cnt_nbits-1:0] c_guard_ld =
        c_cnt_nbits'((p_guard_cycles > 0) ? (p_guard_cycles - 1) : 0);

    // Bit 1 of the encoding is the owning domain, so out_domain is a plain wire.
    typedef enum logic [1:0] {
        SLOT0  = 2'd0,
        GUARD0 = 2'd1,
        SLOT1  = 2'd2,
        GUARD1 = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_cnt_nbits-1:0] r_cnt;
    logic [c_cnt_nbits-1:0] w_cnt_nxt;
    logic [15:0]            r_xfer_cnt0;
    logic [15:0]            r_xfer_cnt1;
    logic                   w_fire0;
    logic                   w_fire1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= SLOT0;
            r_cnt   <= c_slot_ld;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (en) begin
            if (r_cnt != '0) begin
                w_cnt_nxt = r_cnt - 1'b1;
            end else begin
                case (r_state)
                    SLOT0: begin
                        if (p_guard_cycles == 0) begin
                            w_state_nxt = SLOT1;
                            w_cnt_nxt   = c_slot_ld;
                        end else begin
                            w_state_nxt = GUARD0;
                            w_cnt_nxt   = c_guard_ld;
                        end
                    end
                    GUARD0: begin
                        w_state_nxt = SLOT1;
                        w_cnt_nxt   = c_slot_ld;
                    end
                    SLOT1: begin
                        if (p_guard_cycles == 0) begin
                            w_state_nxt = SLOT0;
                            w_cnt_nxt   = c_slot_ld;
                        end else begin
                            w_state_nxt = GUARD1;
                            w_cnt_nxt   = c_guard_ld;
                        end
                    end
                    default: begin
                        w_state_nxt = SLOT0;
                        w_cnt_nxt   = c_slot_ld;
                    end
                endcase
            end
        end
    end

    // Grant path: only the slot owner ever sees rdy; guards and en=0 block everything.
    always_comb begin
        out_val = 1'b0;
        out_msg = '0;
        in0_rdy = 1'b0;
        in1_rdy = 1'b0;
        case (r_state)
            SLOT0: begin
                out_msg = in0_msg;
                out_val = en & in0_val;
                in0_rdy = en & out_rdy;
            end
            SLOT1: begin
                out_msg = in1_msg;
                out_val = en & in1_val;
                in1_rdy = en & out_rdy;
            end
            default: begin
                out_val = 1'b0;
            end
        endcase
    end

    assign out_domain = r_state[1];
    assign guard      = (r_state == GUARD0) || (r_state == GUARD1);
    assign w_fire0    = en & (r_state == SLOT0) & in0_val & out_rdy;
    assign w_fire1    = en & (r_state == SLOT1) & in1_val & out_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_xfer_cnt0 <= '0;
            r_xfer_cnt1 <= '0;
        end else begin
            if (w_fire0) r_xfer_cnt0 <= r_xfer_cnt0 + 16'd1;
            if (w_fire1) r_xfer_cnt1 <= r_xfer_cnt1 + 16'd1;
        end
    end

    assign xfer_cnt0 = r_xfer_cnt0;
    assign xfer_cnt1 = r_xfer_cnt1;

endmodule
